congestion_estimator: RTL and testbench

- Producer of the 2-bit `congestion_level` consumed by the intersection traffic controller.
- Counts vehicle-detector pulses on the NS and EW approaches over a fixed window.
- Quantizes the busier approach into levels 0..3 using thresholds with hysteresis.
- Flags stuck-high detectors on `sensor_fault`, which the top level wires to the controller's `fail_safe_en`.

---
 rtl/congestion_estimator.sv | 144 ++++++++++++++
 tb/tb_congestion_estimator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/congestion_estimator.sv
// Windowed vehicle-pulse counter for the NS/EW approaches that publishes a
// hysteretic 2-bit congestion level and a sticky stuck-detector fault flag.
module congestion_estimator #(
  parameter int WINDOW_TICKS = 100,
  parameter int COUNT_W      = 8,
  parameter int TH1          = 4,
  parameter int TH2          = 8,
  parameter int TH3          = 12,
  parameter int HYST         = 2,
  parameter int STUCK_TICKS  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               det_ns,
  input  logic               det_ew,
  output logic [1:0]         congestion_level,
  output logic               level_valid,
  output logic               sensor_fault,
  output logic [COUNT_W-1:0] cnt_ns_dbg,
  output logic [COUNT_W-1:0] cnt_ew_dbg
);

  localparam int WCNT_W = $clog2(WINDOW_TICKS);
  localparam int ST_W   = $clog2(STUCK_TICKS + 1);

  localparam logic [WCNT_W-1:0]  L_WLAST  = WCNT_W'(WINDOW_TICKS - 1);
  localparam logic [COUNT_W-1:0] L_CMAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W:0]   L_TH1    = (COUNT_W + 1)'(TH1);
  localparam logic [COUNT_W:0]   L_TH2    = (COUNT_W + 1)'(TH2);
  localparam logic [COUNT_W:0]   L_TH3    = (COUNT_W + 1)'(TH3);
  localparam logic [COUNT_W:0]   L_HYST   = (COUNT_W + 1)'(HYST);
  localparam logic [ST_W-1:0]    L_STLAST = ST_W'(STUCK_TICKS - 1);
  localparam logic [ST_W-1:0]    L_STMAX  = ST_W'(STUCK_TICKS);

  // Index 0 is the NS approach, index 1 is EW.
  logic [1:0]         r_meta;
  logic [1:0]         r_sync;
  logic [1:0]         r_prev;
  logic [COUNT_W-1:0] r_cnt   [2];
  logic [ST_W-1:0]    r_stuck [2];
  logic [WCNT_W-1:0]  r_wcnt;
  logic [1:0]         r_level;
  logic               r_valid;
  logic               r_fault;
  logic [COUNT_W-1:0] r_dbgNs;
  logic [COUNT_W-1:0] r_dbgEw;

  logic [1:0]         w_edge;
  logic               w_eval;
  logic [COUNT_W-1:0] w_metric;
  logic [COUNT_W:0]   w_metricUp;
  logic [COUNT_W:0]   w_metricDn;
  logic [1:0]         w_up;
  logic [1:0]         w_down;
  logic               w_stuckHit;

  assign w_edge = r_sync & ~r_prev;
  assign w_eval = (r_wcnt == L_WLAST);

  always_comb begin
    w_metric   = (r_cnt[0] >= r_cnt[1]) ? r_cnt[0] : r_cnt[1];
    w_metricUp = {1'b0, w_metric};
    w_metricDn = w_metricUp + L_HYST;
    w_up       = 2'(w_metricUp >= L_TH1) + 2'(w_metricUp >= L_TH2) + 2'(w_metricUp >= L_TH3);
    w_down     = 2'(w_metricDn >= L_TH1) + 2'(w_metricDn >= L_TH2) + 2'(w_metricDn >= L_TH3);
    w_stuckHit = (r_sync[0] && (r_stuck[0] == L_STLAST)) ||
                 (r_sync[1] && (r_stuck[1] == L_STLAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= {det_ew, det_ns};
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // An edge seen on the evaluation cycle seeds the next window's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i]   <= '0;
        r_stuck[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_eval)
          r_cnt[i] <= w_edge[i] ? COUNT_W'(1) : '0;
        else if (w_edge[i] && (r_cnt[i] != L_CMAX))
          r_cnt[i] <= r_cnt[i] + 1'b1;

        if (!r_sync[i])
          r_stuck[i] <= '0;
        else if (r_stuck[i] != L_STMAX)
          r_stuck[i] <= r_stuck[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wcnt <= '0;
    else if (w_eval)
      r_wcnt <= '0;
    else
      r_wcnt <= r_wcnt + 1'b1;
  end

  // Level tests the registered fault, so a fault raised on the evaluation
  // cycle still lets that evaluation land before the level freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_dbgNs <= '0;
      r_dbgEw <= '0;
    end else begin
      r_valid <= w_eval;
      r_fault <= r_fault | w_stuckHit;
      if (w_eval) begin
        r_dbgNs <= r_cnt[0];
        r_dbgEw <= r_cnt[1];
        if (!r_fault) begin
          if (w_up > r_level)
            r_level <= w_up;
          else if (w_down < r_level)
            r_level <= w_down;
        end
      end
    end
  end

  assign congestion_level = r_level;
  assign level_valid      = r_valid;
  assign sensor_fault     = r_fault;
  assign cnt_ns_dbg       = r_dbgNs;
  assign cnt_ew_dbg       = r_dbgEw;

endmodule

// File: tb/tb_congestion_estimator.sv
// Directed bench for congestion_estimator: hand-computed levels, debug counts,
// strobe timing, window-boundary edge crediting, stuck-fault freeze and reset.
module tb_congestion_estimator;

  logic       clk;
  logic       rst;
  logic       det_ns;
  logic       det_ew;
  logic [1:0] congestion_level;
  logic       level_valid;
  logic       sensor_fault;
  logic [7:0] cnt_ns_dbg;
  logic [7:0] cnt_ew_dbg;

  int vectors;
  int miscompares;

  congestion_estimator #(
    .WINDOW_TICKS(100), .COUNT_W(8), .TH1(4), .TH2(8), .TH3(12),
    .HYST(2), .STUCK_TICKS(50)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .det_ns           (det_ns),
    .det_ew           (det_ew),
    .congestion_level (congestion_level),
    .level_valid      (level_valid),
    .sensor_fault     (sensor_fault),
    .cnt_ns_dbg       (cnt_ns_dbg),
    .cnt_ew_dbg       (cnt_ew_dbg)
  );

  // 10-time-unit clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Level, fault and both debug counts in one go.
  task automatic checkWindow(input string tag, input int lvl, input int ns,
                             input int ew, input int flt);
    checkOutput({tag, "_level"}, 32'(congestion_level), lvl);
    checkOutput({tag, "_dbg_ns"}, 32'(cnt_ns_dbg), ns);
    checkOutput({tag, "_dbg_ew"}, 32'(cnt_ew_dbg), ew);
    checkOutput({tag, "_fault"}, 32'(sensor_fault), flt);
  endtask

  // Pulses of 2 high / 3 low cycles; starts and ends 1 unit after a rising edge
  // and consumes 5 rising edges per pulse slot.
  task automatic applyStimulus(input int nNs, input int nEw);
    int slots;
    slots = (nNs > nEw) ? nNs : nEw;
    for (int i = 0; i < slots; i++) begin
      det_ns = (i < nNs);
      det_ew = (i < nEw);
      repeat (2) @(posedge clk);
      #1;
      det_ns = 1'b0;
      det_ew = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for the next valid strobe; the number of rising edges it took
  // is itself checked, and a timeout shows up as a wrong edge count.
  task automatic waitStrobe(input string tag, input int expEdges);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 250) begin
      @(posedge clk);
      #1;
      n++;
      if (level_valid) seen = 1'b1;
    end
    checkOutput({tag, "_strobe_edges"}, n, expEdges);
  endtask

  initial begin
    int faultAt;
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    det_ns = 1'b0;
    det_ew = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_valid", 32'(level_valid), 0);
    checkWindow("rst", 0, 0, 0, 0);

    // Idle: strobes every 100 edges, single-cycle wide.
    @(negedge clk);
    rst = 1'b0;
    waitStrobe("idle1", 100);
    checkWindow("idle1", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("valid_one_cycle", 32'(level_valid), 0);
    waitStrobe("idle2", 99);
    waitStrobe("idle3", 100);
    checkWindow("idle3", 0, 0, 0, 0);

    // 9 NS / 3 EW: metric 9 -> level 2.
    applyStimulus(9, 3);
    waitStrobe("winA", 55);
    checkWindow("winA", 2, 9, 3, 0);

    // 7: up=1, down=2 -> hold 2.
    applyStimulus(7, 0);
    waitStrobe("winB", 65);
    checkWindow("winB", 2, 7, 0, 0);

    // 5: down=1 -> 1.
    applyStimulus(5, 0);
    waitStrobe("winC", 75);
    checkWindow("winC", 1, 5, 0, 0);

    // 13: up=3 -> jump to 3.
    applyStimulus(13, 0);
    waitStrobe("winD", 35);
    checkWindow("winD", 3, 13, 0, 0);

    // Empty window: down=0 -> straight to 0.
    waitStrobe("winE", 100);
    checkWindow("winE", 0, 0, 0, 0);

    // 4 pulses, then one edge landing on the wcnt==99 cycle (sync rises at
    // edge 99); it must be credited to the following window.
    applyStimulus(4, 0);
    repeat (77) @(posedge clk);
    #1;
    det_ns = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    det_ns = 1'b0;
    waitStrobe("winF", 1);
    checkWindow("winF", 1, 4, 0, 0);

    // Carried edge plus 2 pulses = 3; metric+HYST=5 keeps level 1.
    applyStimulus(2, 0);
    waitStrobe("winG", 90);
    checkWindow("winG", 1, 3, 0, 0);

    applyStimulus(9, 0);
    waitStrobe("winH", 55);
    checkWindow("winH", 2, 9, 0, 0);

    // Hold EW high for 60 edges: sync high from edge 2, fault after 50 high cycles.
    faultAt = 0;
    det_ew = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (sensor_fault && faultAt == 0) faultAt = k;
    end
    det_ew = 1'b0;
    checkOutput("fault_edge", faultAt, 52);
    waitStrobe("winI", 40);
    checkWindow("winI", 2, 0, 1, 1);

    // Frozen: 15 pulses would be level 3.
    applyStimulus(15, 0);
    waitStrobe("winJ", 25);
    checkWindow("winJ", 2, 15, 0, 1);

    // Asynchronous reset mid-window with partial counts 6/4.
    applyStimulus(6, 4);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(level_valid), 0);
    checkWindow("arst", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(2, 1);
    waitStrobe("post_rst", 89);
    checkWindow("post_rst", 0, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
